// File: rtl/operand_edge_feeder.sv
// -----------------------------------------------------------------------------
// operand_edge_feeder
//
// Feeds one edge (a row's A side or a column's B side) of the systolic MAC
// array. The host appends operands to a local buffer while the block is idle.
// On start the block waits SKEW idle cycles, then offers the operands one at a
// time to the edge MAC. After the last operand it raises out_finished so the
// MAC can latch its accumulated result. Each instance has its own SKEW, which
// staggers the edges and forms the systolic wavefront.
//
// Handshake with the MAC (out_data / out_waiting / out_ready):
//   out_waiting is the valid and out_ready is the ready. An operand transfers
//   on a rising edge where both are 1. While out_waiting is 1, out_data is held
//   stable. After each transfer out_waiting drops for at least one cycle. It
//   returns only after out_ready has been seen low and then high again. This
//   prevents one ready window from consuming two operands.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   wr_en, wr_data host append strobe and operand (honoured in IDLE only)
//   start          stream the loaded vector (honoured in IDLE or DONE)
//   load_count     number of operands currently loaded
//   busy           high in SKEW, OFFER and GAP
//   out_data       operand to the MAC (A_in / B_in)
//   out_waiting    operand valid (A_in_waiting / B_in_waiting)
//   out_finished   vector complete (A_in_finished / B_in_finished)
//   out_ready      MAC can accept (A_in_ready / B_in_ready)
//   state_dbg      current FSM state: 0 IDLE, 1 SKEW, 2 OFFER, 3 GAP, 4 DONE
// -----------------------------------------------------------------------------
module operand_edge_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int SKEW       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     start,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     busy,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_waiting,
    output logic                     out_finished,
    input  logic                     out_ready,
    output logic [2:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKEW  = 3'd1,
        S_OFFER = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    // count_q is both the write pointer and the loaded operand count.
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           rd_q, rd_d;
    logic [7:0]              skew_q, skew_d;
    logic                    seen_low_q, seen_low_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    wr_fire;
    logic                    xfer;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign wr_fire    = wr_en && (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    assign xfer       = out_waiting && out_ready;
    assign load_count = count_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_d       = rd_q;
        skew_d     = skew_q;
        seen_low_d = seen_low_q;

        // A write in the same cycle as start is counted into the vector.
        if (wr_fire) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rd_d = '0;
                    if (count_d == '0) begin
                        state_d = S_DONE;
                    end else if (SKEW == 0) begin
                        state_d = S_OFFER;
                    end else begin
                        state_d = S_SKEW;
                        skew_d  = 8'(SKEW);
                    end
                end
            end
            S_SKEW: begin
                skew_d = skew_q - 8'd1;
                if (skew_q == 8'd1) begin
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (xfer) begin
                    rd_d       = rd_q + 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = (rd_q == count_q - 1'b1) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (!out_ready) begin
                    seen_low_d = 1'b1;
                end
                if (seen_low_q && out_ready) begin
                    state_d = S_OFFER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state, so out_data is loaded
        // on entry to OFFER. Bypass the write port when the operand being
        // offered is written in this same cycle.
        data_d = out_data;
        if (state_d == S_OFFER) begin
            if (wr_fire && (count_q[AW-1:0] == rd_d[AW-1:0])) begin
                data_d = wr_data;
            end else begin
                data_d = mem[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            rd_q         <= '0;
            skew_q       <= '0;
            seen_low_q   <= 1'b0;
            out_data     <= '0;
            out_waiting  <= 1'b0;
            out_finished <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            skew_q       <= skew_d;
            seen_low_q   <= seen_low_d;
            out_data     <= data_d;
            out_waiting  <= (state_d == S_OFFER);
            out_finished <= (state_d == S_DONE);
            busy         <= (state_d == S_SKEW) || (state_d == S_OFFER) ||
                            (state_d == S_GAP);
        end
    end

    // Buffer contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[count_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_operand_edge_feeder.sv
module tb_operand_edge_feeder;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SKEW0 = 0;
  localparam int SKEW1 = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0]  o_data [2];
  logic          o_wait [2];
  logic          o_fin  [2];
  logic          o_busy [2];
  logic          rdy    [2];
  logic [CW-1:0] lcnt   [2];
  logic [2:0]    st     [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  operand_edge_feeder #(.DATA_WIDTH(W), .DEPTH(DEPTH), .SKEW(SKEW0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .load_count(lcnt[0]), .busy(o_busy[0]), .out_data(o_data[0]),
    .out_waiting(o_wait[0]), .out_finished(o_fin[0]), .out_ready(rdy[0]),
    .state_dbg(st[0])
  );

  operand_edge_feeder #(.DATA_WIDTH(W), .DEPTH(DEPTH), .SKEW(SKEW1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .load_count(lcnt[1]), .busy(o_busy[1]), .out_data(o_data[1]),
    .out_waiting(o_wait[1]), .out_finished(o_fin[1]), .out_ready(rdy[1]),
    .state_dbg(st[1])
  );

  // ---------------- reference model / scoreboard state ----------------
  logic [W-1:0] model_buf[$];   // operands the feeder should hold
  bit           loading;        // host writes accepted (before first start)
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;
  int t_start = 0;
  int run_len = 0;
  int nxfer     [2];
  int last_xfer [2];
  bit seen_w    [2];
  bit fin_prev  [2];
  bit drop_pend [2];
  int ready_mode = 0;           // 0 MAC model, 1 held high, 2 bench-driven

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor + MAC ready model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        bit xfer;
        logic [W-1:0] e;
        xfer = o_wait[g] && rdy[g];
        if (o_wait[g] && !seen_w[g]) begin
          seen_w[g] = 1'b1;
          chk($sformatf("first_offer_latency_u%0d", g), cyc - t_start,
              ((g == 0) ? SKEW0 : SKEW1) + 1);
        end
        if (xfer) begin
          nxfer[g]++;
          last_xfer[g] = cyc;
          if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer_u%0d: got data %0d expected no transfer", g, o_data[g]);
          end else begin
            if (g == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            chk($sformatf("out_data_u%0d", g), o_data[g], e);
          end
        end
        if (o_fin[g] && !fin_prev[g]) begin
          chk($sformatf("finish_cycle_u%0d", g), cyc,
              (run_len > 0) ? last_xfer[g] + 1 : t_start + 1);
        end
        fin_prev[g] = o_fin[g];
        if (ready_mode == 0) begin
          if (drop_pend[g]) begin
            rdy[g] = 1'b0;
            drop_pend[g] = 1'b0;
          end else if (!rdy[g]) begin
            rdy[g] = 1'b1;
          end
          if (xfer) drop_pend[g] = 1'b1;
        end else if (ready_mode == 1) begin
          rdy[g] = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic phase_init();
    ready_mode = 0;
    for (int g = 0; g < 2; g++) begin
      rdy[g] = 1'b1;
      drop_pend[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_buf.delete();
    exp_q0.delete();
    exp_q1.delete();
    loading = 1'b1;
    phase_init();
    @(negedge clk);
  endtask

  task automatic write_op(input logic [W-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    if (loading && model_buf.size() < DEPTH) model_buf.push_back(v);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_op(input bit with_wr, input logic [W-1:0] v);
    if (with_wr) begin
      wr_en = 1'b1;
      wr_data = v;
      if (loading && model_buf.size() < DEPTH) model_buf.push_back(v);
    end
    start = 1'b1;
    loading = 1'b0;
    t_start = cyc;
    run_len = model_buf.size();
    for (int g = 0; g < 2; g++) begin
      seen_w[g] = 1'b0;
      nxfer[g] = 0;
      last_xfer[g] = 0;
    end
    foreach (model_buf[i]) begin
      exp_q0.push_back(model_buf[i]);
      exp_q1.push_back(model_buf[i]);
    end
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    if (run_len > 0) begin
      chk("busy_after_start_u0", o_busy[0], 1);
      chk("busy_after_start_u1", o_busy[1], 1);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(o_fin[0] && o_fin[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, o_fin[0] && o_fin[1], 1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_xfers_u%0d", name, g), nxfer[g], run_len);
      chk($sformatf("%s_load_count_u%0d", name, g), lcnt[g], model_buf.size());
      chk($sformatf("%s_state_u%0d", name, g), st[g], ST_DONE);
      chk($sformatf("%s_busy_u%0d", name, g), o_busy[g], 0);
      chk($sformatf("%s_waiting_u%0d", name, g), o_wait[g], 0);
    end
    chk({name, "_pending_u0"}, exp_q0.size(), 0);
    chk({name, "_pending_u1"}, exp_q1.size(), 0);
  endtask

  task automatic check_idle_zero(input string name);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_data_u%0d", name, g), o_data[g], 0);
      chk($sformatf("%s_waiting_u%0d", name, g), o_wait[g], 0);
      chk($sformatf("%s_finished_u%0d", name, g), o_fin[g], 0);
      chk($sformatf("%s_busy_u%0d", name, g), o_busy[g], 0);
      chk($sformatf("%s_load_count_u%0d", name, g), lcnt[g], 0);
      chk($sformatf("%s_state_u%0d", name, g), st[g], ST_IDLE);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int len;
    phase_init();
    for (int g = 0; g < 2; g++) begin
      fin_prev[g] = 1'b0;
      seen_w[g] = 1'b1;
      nxfer[g] = 0;
      last_xfer[g] = 0;
    end
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    do_reset();

    // Fixed vector 3, 5, 7 with the MAC handshake model.
    write_op(16'd3);
    write_op(16'd5);
    write_op(16'd7);
    start_op(1'b0, '0);
    wait_done("vec357");

    // Ready held high: one transfer, then a stall in GAP until ready toggles.
    do_reset();
    for (int i = 0; i < 4; i++) write_op(W'($urandom_range(0, 65535)));
    ready_mode = 1;
    start_op(1'b0, '0);
    n = 0;
    while (!(nxfer[0] >= 1 && nxfer[1] >= 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("stall_xfers_u%0d", g), nxfer[g], 1);
      chk($sformatf("stall_waiting_u%0d", g), o_wait[g], 0);
      chk($sformatf("stall_state_u%0d", g), st[g], ST_GAP);
    end
    ready_mode = 2;
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    @(negedge clk);
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    ready_mode = 0;
    wait_done("stall");

    // Overfill: DEPTH+2 writes, only the first DEPTH are kept.
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) write_op(W'($urandom_range(0, 65535)));
    chk("sat_load_count_u0", lcnt[0], DEPTH);
    chk("sat_load_count_u1", lcnt[1], DEPTH);
    start_op(1'b0, '0);
    wait_done("saturate");
    // Writes in DONE are ignored; replay streams the same vector.
    write_op(W'($urandom_range(0, 65535)));
    chk("done_write_load_count_u0", lcnt[0], DEPTH);
    chk("done_write_state_u0", st[0], ST_DONE);
    start_op(1'b0, '0);
    wait_done("replay");

    // Asynchronous reset while in OFFER after 2 of 4 transfers.
    do_reset();
    for (int i = 0; i < 4; i++) write_op(W'($urandom_range(0, 65535)));
    start_op(1'b0, '0);
    n = 0;
    while (nxfer[0] < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midstream_two_xfers", nxfer[0], 2);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!o_wait[0] && n < 100);
    chk("midstream_in_offer", o_wait[0], 1);
    #1;
    rst = 1'b1;
    #1;
    check_idle_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_buf.delete();
    exp_q0.delete();
    exp_q1.delete();
    loading = 1'b1;
    phase_init();
    @(negedge clk);
    check_idle_zero("after_reset");

    // Empty start: finished next cycle, no offer; writes in DONE ignored.
    start_op(1'b0, '0);
    repeat (10) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("empty_finished_u%0d", g), o_fin[g], 1);
      chk($sformatf("empty_no_offer_u%0d", g), seen_w[g], 0);
    end
    write_op(W'($urandom_range(0, 65535)));
    start_op(1'b0, '0);
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("empty_done_load_count_u%0d", g), lcnt[g], 0);
      chk($sformatf("empty_done_finished_u%0d", g), o_fin[g], 1);
      chk($sformatf("empty_done_no_offer_u%0d", g), seen_w[g], 0);
    end

    // Random vectors; the last write shares its cycle with start.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      len = (it == 0) ? 1 : $urandom_range(2, DEPTH);
      for (int i = 0; i < len - 1; i++) write_op(W'($urandom_range(0, 65535)));
      start_op(1'b1, W'($urandom_range(0, 65535)));
      wait_done($sformatf("random%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
